// File: rtl/rf_pkg.sv
// Purpose: shared constants and strobe type for the 32x16 register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rf_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

  // One bit per architectural register, bit i selects register i.
  typedef logic [NUM_REGS-1:0] strobe_t;

  // Register 0 is hardwired: it never takes a write or a pending mark.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/dec5to32.sv
// Purpose: 5-to-32 one-hot decoder with enable (write and issue strobes).
// Latency: combinational, 0 cycles.
// Backpressure: none; output follows inputs every cycle.
module dec5to32
  import rf_pkg::*;
(
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output strobe_t           onehot
);

  // Drive exactly one strobe bit when enabled, none otherwise.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_32x16.sv
// Purpose: 32x16 register file, two combinational read ports, pending-write scoreboard.
// Latency: write and scoreboard update 1 edge; reads 0 cycles (optional same-cycle bypass).
// Backpressure: none; a write or issue is accepted every cycle.
module reg_file_32x16 #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy1,
  output logic              rd_busy2
);

  import rf_pkg::*;

  localparam logic BYP_ON = (BYPASS != 0);

  logic              wr_act;
  logic              iss_act;
  strobe_t           wr_stb;
  strobe_t           iss_stb;
  strobe_t           pend;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              byp1;
  logic              byp2;
  logic              wr_done1;
  logic              wr_done2;

  // Address 0 is filtered before decoding so r0 never gets a strobe.
  assign wr_act  = wr_en  && !is_zero_reg(wr_addr);
  assign iss_act = iss_en && !is_zero_reg(iss_addr);

  dec5to32 u_wr_dec (
    .en     (wr_act),
    .addr   (wr_addr),
    .onehot (wr_stb)
  );

  dec5to32 u_iss_dec (
    .en     (iss_act),
    .addr   (iss_addr),
    .onehot (iss_stb)
  );

  // Storage and scoreboard: clear on write-back, then set on issue so a
  // newer producer of the same register keeps it pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      pend <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_stb[i]) begin
          regs[i] <= wr_data;
        end
      end
      pend <= (pend & ~wr_stb) | iss_stb;
    end
  end

  // Forward the write-back value only outside reset so outputs read 0 in reset.
  assign byp1 = BYP_ON && rst_n && wr_stb[rd_addr1];
  assign byp2 = BYP_ON && rst_n && wr_stb[rd_addr2];

  assign rd_data1 = byp1 ? wr_data : regs[rd_addr1];
  assign rd_data2 = byp2 ? wr_data : regs[rd_addr2];

  // A completing write hides the pending bit, unless the same register is
  // being re-issued this cycle.
  assign wr_done1 = BYP_ON && wr_stb[rd_addr1] && !iss_stb[rd_addr1];
  assign wr_done2 = BYP_ON && wr_stb[rd_addr2] && !iss_stb[rd_addr2];

  assign rd_busy1 = pend[rd_addr1] && !wr_done1;
  assign rd_busy2 = pend[rd_addr2] && !wr_done2;

endmodule

// File: tb/tb_reg_file_32x16.sv
module tb_reg_file_32x16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;

  logic [15:0] b_d1, b_d2, n_d1, n_d2;
  logic        b_b1, b_b2, n_b1, n_b2;

  always #5 clk = ~clk;

  reg_file_32x16 #(.DATA_W(16), .ADDR_W(5), .BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(b_d1), .rd_data2(b_d2),
    .rd_busy1(b_b1), .rd_busy2(b_b2)
  );

  reg_file_32x16 #(.DATA_W(16), .ADDR_W(5), .BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_d1), .rd_data2(n_d2),
    .rd_busy1(n_b1), .rd_busy2(n_b2)
  );

  // Reference model: architectural register contents and pending set.
  logic [15:0] mregs [32];
  bit          mpend [32];

  typedef struct {
    string       tag;
    logic [15:0] d1b, d2b, d1n, d2n;
    logic        b1b, b2b, b1n, b2n;
  } exp_t;

  exp_t q[$];
  exp_t e;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = 16'h0;
      mpend[i] = 1'b0;
    end
  endfunction

  // Value a reader sees this cycle given the driven inputs.
  function automatic logic [15:0] exp_data(input bit byp, input logic [4:0] ra);
    if (byp && rst_n && wr_en && wr_addr != 0 && wr_addr == ra) return wr_data;
    return mregs[ra];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] ra);
    bit completing;
    completing = byp && wr_en && wr_addr != 0 && wr_addr == ra &&
                 !(iss_en && iss_addr == ra);
    return mpend[ra] && !completing;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: got %h expected %h", e.tag, name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expected outputs, then advance the model.
  task automatic step(input bit r, input bit we, input logic [4:0] wa, input logic [15:0] wd,
                      input bit ie, input logic [4:0] ia,
                      input logic [4:0] a1, input logic [4:0] a2, input string tag);
    exp_t x;
    rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia; rd_addr1 = a1; rd_addr2 = a2;
    if (!r) model_reset();
    x.tag = tag;
    x.d1b = exp_data(1'b1, a1); x.d2b = exp_data(1'b1, a2);
    x.d1n = exp_data(1'b0, a1); x.d2n = exp_data(1'b0, a2);
    x.b1b = exp_busy(1'b1, a1); x.b2b = exp_busy(1'b1, a2);
    x.b1n = exp_busy(1'b0, a1); x.b2n = exp_busy(1'b0, a2);
    q.push_back(x);
    @(posedge clk);
    #1;
    if (r) begin
      if (we && wa != 0) begin
        mregs[wa] = wd;
        mpend[wa] = 1'b0;
      end
      if (ie && ia != 0) mpend[ia] = 1'b1;
    end
  endtask

  // Monitor: the read ports present a result every cycle; compare mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("byp_d1", b_d1, e.d1b);
      chk("byp_d2", b_d2, e.d2b);
      chk("byp_b1", {15'h0, b_b1}, {15'h0, e.b1b});
      chk("byp_b2", {15'h0, b_b2}, {15'h0, e.b2b});
      chk("nob_d1", n_d1, e.d1n);
      chk("nob_d2", n_d2, e.d2n);
      chk("nob_b1", {15'h0, n_b1}, {15'h0, e.b1n});
      chk("nob_b2", {15'h0, n_b2}, {15'h0, e.b2n});
    end
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
    model_reset();
    @(posedge clk);
    #1;

    // Reset held with random traffic.
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 5'($urandom_range(0, 31)), 16'($urandom), 1'b1,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), "reset_traffic");
    end

    // All registers read zero after release.
    for (int i = 1; i < 32; i++) begin
      step(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'(i), 5'(32 - i), $sformatf("post_reset_r%0d", i));
    end

    // Basic write/read.
    step(1'b1, 1'b1, 5'd7,  16'hBEEF, 1'b0, 5'd0, 5'd7, 5'd31, "wr_r7");
    step(1'b1, 1'b1, 5'd31, 16'h1234, 1'b0, 5'd0, 5'd7, 5'd31, "wr_r31");
    step(1'b1, 1'b0, 5'd0,  16'h0,    1'b0, 5'd0, 5'd7, 5'd31, "rd_r7_r31");
    step(1'b1, 1'b0, 5'd0,  16'h0,    1'b0, 5'd0, 5'd31, 5'd7, "rd_r31_r7");
    step(1'b1, 1'b0, 5'd0,  16'h0,    1'b0, 5'd0, 5'd0, 5'd0, "rd_r0");

    // r0 protection.
    step(1'b1, 1'b0, 5'd0, 16'h0,    1'b1, 5'd0, 5'd0, 5'd0, "iss_r0");
    step(1'b1, 1'b1, 5'd0, 16'hFFFF, 1'b0, 5'd0, 5'd0, 5'd0, "wr_r0");
    step(1'b1, 1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 5'd0, 5'd0, "rd_r0_after");

    // Bypass on r3.
    step(1'b1, 1'b1, 5'd3, 16'hA5A5, 1'b0, 5'd0, 5'd3, 5'd3, "bypass_r3");
    step(1'b1, 1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 5'd3, 5'd3, "after_r3");

    // Scoreboard on r9.
    step(1'b1, 1'b0, 5'd0, 16'h0,    1'b1, 5'd9, 5'd9, 5'd9, "iss_r9");
    step(1'b1, 1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 5'd9, 5'd9, "busy_r9");
    step(1'b1, 1'b1, 5'd9, 16'h0909, 1'b1, 5'd9, 5'd9, 5'd9, "iss_wr_r9");
    step(1'b1, 1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 5'd9, 5'd9, "still_busy_r9");
    step(1'b1, 1'b1, 5'd9, 16'h9999, 1'b1, 5'd4, 5'd9, 5'd4, "wr_r9_iss_r4");
    step(1'b1, 1'b0, 5'd0, 16'h0,    1'b0, 5'd0, 5'd9, 5'd4, "free_r9");
    step(1'b1, 1'b1, 5'd20, 16'h2020, 1'b0, 5'd0, 5'd20, 5'd20, "wr_not_pending");

    // Randomised traffic with occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] wa;
      wa = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 59) != 0), ($urandom_range(0, 2) != 0), wa, 16'($urandom),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), $sformatf("rand_%0d", i));
    end

    // Mid-operation reset discards a same-cycle write.
    step(1'b1, 1'b1, 5'd12, 16'h7777, 1'b1, 5'd12, 5'd12, 5'd5, "pre_mid");
    step(1'b1, 1'b0, 5'd0,  16'h0,    1'b1, 5'd5,  5'd12, 5'd5, "pend_mid");
    step(1'b0, 1'b1, 5'd12, 16'h5555, 1'b0, 5'd0,  5'd12, 5'd5, "mid_reset_wr");
    for (int i = 1; i < 32; i++) begin
      step(1'b1, 1'b0, 5'd0, 16'h0, 1'b0, 5'd0, 5'(i), 5'd12, $sformatf("after_mid_r%0d", i));
    end

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
